// File: rtl/pp_memory_sync_pkg.sv
// Shared constants and types for the pp_memory_sync single-port memory.
// The clear sequencer state type is only used when MEM_CLEAR_EN is defined.
package pp_memory_sync_pkg;

    localparam int word_size = 16;
    localparam int addr_size = 10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } clr_state_t;

endpackage

// File: rtl/pp_mem_clear_seq.sv
// Post-reset clear sequencer: zeroes one word per cycle from address 0 to
// DEPTH-1, then idles. Used by pp_memory_sync only when MEM_CLEAR_EN is defined.
module pp_mem_clear_seq
    import pp_memory_sync_pkg::*;
#(
    parameter int ADDR_W = addr_size
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              o_busy,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output clr_state_t        o_state
);

    clr_state_t        r_state;
    clr_state_t        w_next_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_next_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
            r_addr  <= '0;
        end else begin
            r_state <= w_next_state;
            r_addr  <= w_next_addr;
        end
    end

    // Reset holds CLEAR, but no word is written until rst_n is released.
    always_comb begin
        w_next_state = r_state;
        w_next_addr  = r_addr;
        o_we         = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                o_we = rst_n;
                if (r_addr == {ADDR_W{1'b1}}) begin
                    w_next_state = ST_IDLE;
                    w_next_addr  = '0;
                end else begin
                    w_next_addr = r_addr + 1'b1;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign o_busy  = (r_state == ST_CLEAR);
    assign o_addr  = r_addr;
    assign o_state = r_state;

endmodule

// File: rtl/pp_memory_sync.sv
// Single-port byte-writable synchronous memory with 1-cycle registered reads.
// Define MEM_CLEAR_EN to zero the whole array after every reset release.
module pp_memory_sync
    import pp_memory_sync_pkg::*;
#(
    parameter int    WORD_W    = word_size,
    parameter int    ADDR_W    = addr_size,
    parameter string INIT_FILE = ""
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req,
    input  logic                we,
    input  logic [WORD_W/8-1:0] be,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [WORD_W-1:0]   d_in,
    output logic                ready,
    output logic [WORD_W-1:0]   d_out,
    output logic                valid,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = WORD_W / 8;

    logic [WORD_W-1:0] r_bank [DEPTH];
    logic [WORD_W-1:0] r_dout;
    logic              r_valid;
    logic              w_busy;
    logic              w_accept;
    logic              w_rd;
    logic              w_wr;

`ifdef MEM_CLEAR_EN
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    clr_state_t        w_clr_state;

    pp_mem_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .o_busy  (w_busy),
        .o_we    (w_clr_we),
        .o_addr  (w_clr_addr),
        .o_state (w_clr_state)
    );

    // Clear writes win; user requests are already blocked by ready=0.
    always_ff @(posedge clk) begin
        if (w_clr_we && (w_clr_state == ST_CLEAR)) begin
            r_bank[w_clr_addr] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) r_bank[addr][8*i +: 8] <= d_in[8*i +: 8];
            end
        end
    end
`else
    assign w_busy = 1'b0;

    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) r_bank[addr][8*i +: 8] <= d_in[8*i +: 8];
            end
        end
    end
`endif

    assign ready    = rst_n & ~w_busy;
    assign w_accept = req & ready;
    assign w_rd     = w_accept & ~we;
    assign w_wr     = w_accept & we;

    // Async reset drops valid at once, aborting any read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= w_rd;
            if (w_rd) r_dout <= r_bank[addr];
        end
    end

    assign d_out = r_dout;
    assign valid = r_valid;
    assign busy  = w_busy;

endmodule
